case_8_mul_pipe_vld: RTL and testbench

- Parametrised successor to the generated combinational signed multiplier cores.
- Pipelined multiplier with configurable depth, per-operand signedness, truncate or saturate output mode, and an overflow flag.
- Uses a valid/ready handshake plus the generated-core `ce` clock-enable, so scheduled datapaths can stall it.
- Sits between HLS-scheduled operand registers and downstream FIFOs/accumulators.

---
 rtl/case_8_mul_pkg.sv | 28 ++
 rtl/case_8_mul_sat_narrow.sv | 46 ++++
 rtl/case_8_mul_pipe_vld.sv | 129 ++++++++++++
 tb/tb_case_8_mul_pipe_vld.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_8_mul_pkg.sv
// Shared definitions for the pipelined valid/ready multiplier: depth limit,
// output-mode enum and the saturation bound helpers.
package case_8_mul_pkg;

    localparam int MUL_MAX_STAGE = 8;

    typedef enum logic {
        MUL_TRUNC = 1'b0,
        MUL_SAT   = 1'b1
    } mul_mode_t;

    // Largest value representable in `width` bits, zero-extended to 64 bits.
    function automatic logic [63:0] sat_limit_hi(input int width, input bit is_signed);
        if (is_signed) begin
            return (64'd1 << (width - 1)) - 64'd1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

    // Smallest value representable in `width` bits, two's complement in 64 bits.
    function automatic logic [63:0] sat_limit_lo(input int width, input bit is_signed);
        if (is_signed) begin
            return ~((64'd1 << (width - 1)) - 64'd1);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/case_8_mul_sat_narrow.sv
// Combinational narrowing of the full product to the output width, with
// wrap or clamp behaviour and the out-of-range flag.
module case_8_mul_sat_narrow
    import case_8_mul_pkg::*;
#(
    parameter int        PW     = 10,
    parameter int        DW     = 6,
    parameter int        SIGNED = 1,
    parameter mul_mode_t MODE   = MUL_TRUNC
) (
    input  logic [PW-1:0] prod_i,
    output logic [DW-1:0] dout_o,
    output logic          ovf_o
);

    localparam logic [63:0] LIM_HI = sat_limit_hi(DW, SIGNED != 0);
    localparam logic [63:0] LIM_LO = sat_limit_lo(DW, SIGNED != 0);

    if (DW >= PW) begin : g_wide
        // Every product fits, so only extension is needed.
        if (SIGNED != 0) begin : g_sext
            assign dout_o = DW'($signed(prod_i));
        end else begin : g_zext
            assign dout_o = DW'(prod_i);
        end
        assign ovf_o = 1'b0;
    end else begin : g_narrow
        logic fits;

        // A value fits when all discarded bits match the kept sign bit (or are zero).
        if (SIGNED != 0) begin : g_sfit
            assign fits = (prod_i[PW-1:DW-1] == {(PW-DW+1){prod_i[PW-1]}});
        end else begin : g_ufit
            assign fits = (prod_i[PW-1:DW] == '0);
        end

        always_comb begin
            dout_o = prod_i[DW-1:0];
            ovf_o  = ~fits;
            if (MODE == MUL_SAT && !fits) begin
                dout_o = ((SIGNED != 0) && prod_i[PW-1]) ? LIM_LO[DW-1:0] : LIM_HI[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/case_8_mul_pipe_vld.sv
// Pipelined multiplier with valid/ready handshake and clock enable.
// Optional statistics counters are enabled by defining CASE_8_MUL_PIPE_STATS_EN.
module case_8_mul_pipe_vld
    import case_8_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 6,
    parameter int din1_WIDTH  = 4,
    parameter int dout_WIDTH  = 6,
    parameter int din0_SIGNED = 1,
    parameter int din1_SIGNED = 1,
    parameter int SAT_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
`ifdef CASE_8_MUL_PIPE_STATS_EN
    ,
    output logic [31:0]           stat_acc,
    output logic [15:0]           stat_ovf
`endif
);

    localparam int        PW          = din0_WIDTH + din1_WIDTH;
    localparam int        PROD_SIGNED = ((din0_SIGNED != 0) || (din1_SIGNED != 0)) ? 1 : 0;
    localparam mul_mode_t MODE        = (SAT_MODE != 0) ? MUL_SAT : MUL_TRUNC;

    if (NUM_STAGE < 1 || NUM_STAGE > MUL_MAX_STAGE || ID < 0) begin : g_bad_param
        $error("case_8_mul_pipe_vld: NUM_STAGE must be 1..%0d and ID non-negative", MUL_MAX_STAGE);
    end

    logic signed [din0_WIDTH:0] op0;
    logic signed [din1_WIDTH:0] op1;
    logic        [PW-1:0]       prod;

    // One guard bit per operand lets a single signed multiply cover every signedness mix.
    assign op0  = {(din0_SIGNED != 0) ? din0[din0_WIDTH-1] : 1'b0, din0};
    assign op1  = {(din1_SIGNED != 0) ? din1[din1_WIDTH-1] : 1'b0, din1};
    assign prod = PW'(op0) * PW'(op1);

    logic [PW-1:0]        stageData_q [NUM_STAGE];
    logic [PW-1:0]        stageData_d [NUM_STAGE];
    logic [NUM_STAGE-1:0] stageVld_q;
    logic [NUM_STAGE-1:0] stageVld_d;
    logic                 adv;

    assign adv     = ce & (~stageVld_q[NUM_STAGE-1] | out_rdy);
    assign in_rdy  = adv;
    assign out_vld = stageVld_q[NUM_STAGE-1];

    // The whole pipe moves as one; bubbles travel with it rather than collapsing.
    always_comb begin
        stageVld_d  = stageVld_q;
        stageData_d = stageData_q;
        if (adv) begin
            stageVld_d[0]  = in_vld;
            stageData_d[0] = prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                stageVld_d[i]  = stageVld_q[i-1];
                stageData_d[i] = stageData_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stageVld_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                stageData_q[i] <= '0;
            end
        end else begin
            stageVld_q  <= stageVld_d;
            stageData_q <= stageData_d;
        end
    end

    case_8_mul_sat_narrow #(
        .PW     (PW),
        .DW     (dout_WIDTH),
        .SIGNED (PROD_SIGNED),
        .MODE   (MODE)
    ) u_narrow (
        .prod_i (stageData_q[NUM_STAGE-1]),
        .dout_o (dout),
        .ovf_o  (ovf)
    );

`ifdef CASE_8_MUL_PIPE_STATS_EN
    logic [31:0] statAcc_q;
    logic [31:0] statAcc_d;
    logic [15:0] statOvf_q;
    logic [15:0] statOvf_d;

    // adv already folds in ce, so both counters freeze with the pipe.
    always_comb begin
        statAcc_d = statAcc_q;
        statOvf_d = statOvf_q;
        if (in_vld && adv && statAcc_q != '1) begin
            statAcc_d = statAcc_q + 32'd1;
        end
        if (out_vld && out_rdy && ce && ovf && statOvf_q != '1) begin
            statOvf_d = statOvf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            statAcc_q <= '0;
            statOvf_q <= '0;
        end else begin
            statAcc_q <= statAcc_d;
            statOvf_q <= statOvf_d;
        end
    end

    assign stat_acc = statAcc_q;
    assign stat_ovf = statOvf_q;
`endif

endmodule

// File: tb/tb_case_8_mul_pipe_vld.sv
// Scoreboard bench for case_8_mul_pipe_vld: three instances cover signed
// truncate, signed saturate and unsigned saturate builds.
module tb_case_8_mul_pipe_vld;

    typedef struct packed {
        logic [5:0] d;
        logic       o;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic ceA, vldA, rdyA, ovA, orA, ovfA;
    logic ceB, vldB, rdyB, ovB, orB, ovfB;
    logic ceC, vldC, rdyC, ovC, orC, ovfC;
    logic [5:0] din0A, din0B, din0C, doutA, doutB, doutC;
    logic [3:0] din1A, din1B, din1C;
`ifdef CASE_8_MUL_PIPE_STATS_EN
    logic [31:0] accA, accB, accC;
    logic [15:0] sovA, sovB, sovC;
`endif

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    case_8_mul_pipe_vld u_dutA (
        .clk(clk), .reset(reset), .ce(ceA), .in_vld(vldA), .in_rdy(rdyA),
        .din0(din0A), .din1(din1A), .out_vld(ovA), .out_rdy(orA), .dout(doutA), .ovf(ovfA)
`ifdef CASE_8_MUL_PIPE_STATS_EN
        , .stat_acc(accA), .stat_ovf(sovA)
`endif
    );

    case_8_mul_pipe_vld #(.SAT_MODE(1)) u_dutB (
        .clk(clk), .reset(reset), .ce(ceB), .in_vld(vldB), .in_rdy(rdyB),
        .din0(din0B), .din1(din1B), .out_vld(ovB), .out_rdy(orB), .dout(doutB), .ovf(ovfB)
`ifdef CASE_8_MUL_PIPE_STATS_EN
        , .stat_acc(accB), .stat_ovf(sovB)
`endif
    );

    case_8_mul_pipe_vld #(.din0_SIGNED(0), .din1_SIGNED(0), .SAT_MODE(1)) u_dutC (
        .clk(clk), .reset(reset), .ce(ceC), .in_vld(vldC), .in_rdy(rdyC),
        .din0(din0C), .din1(din1C), .out_vld(ovC), .out_rdy(orC), .dout(doutC), .ovf(ovfC)
`ifdef CASE_8_MUL_PIPE_STATS_EN
        , .stat_acc(accC), .stat_ovf(sovC)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic compareTail(input string tag, input logic [5:0] d, input logic o, input exp_t e);
        checkOutput({tag, "_dout"}, {26'd0, d}, {26'd0, e.d});
        checkOutput({tag, "_ovf"}, {31'd0, o}, {31'd0, e.o});
    endtask

    // Presents one operand pair and returns just after the edge that accepts it.
    task automatic applyStimulus(input int which, input logic [5:0] a, input logic [3:0] b,
                                 input logic [5:0] expD, input logic expO);
        exp_t e;
        logic rdy;
        int   tries;
        e.d   = expD;
        e.o   = expO;
        tries = 0;
        case (which)
            0:       begin vldA = 1'b1; din0A = a; din1A = b; end
            1:       begin vldB = 1'b1; din0B = a; din1B = b; end
            default: begin vldC = 1'b1; din0C = a; din1C = b; end
        endcase
        forever begin
            @(negedge clk);
            case (which)
                0:       rdy = rdyA;
                1:       rdy = rdyB;
                default: rdy = rdyC;
            endcase
            if (rdy) begin
                case (which)
                    0:       qA.push_back(e);
                    1:       qB.push_back(e);
                    default: qC.push_back(e);
                endcase
                break;
            end
            tries++;
            if (tries > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got in_rdy low for %0d cycles, expected accept", tries);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (qA.size() == 0 && qB.size() == 0 && qC.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_drain: got %0d/%0d/%0d pending, expected 0", tag, qA.size(), qB.size(), qC.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Operand accepted at edge N must show on out_vld only after edge N+2.
    task automatic checkLatency(input string tag);
        @(negedge clk);
        checkOutput({tag, "_e0"}, {31'd0, ovA}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, "_e1"}, {31'd0, ovA}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, "_e2"}, {31'd0, ovA}, 32'd1);
    endtask

    // Monitor: every output transfer is compared against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ovA && orA && ceA) begin
                if (qA.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL A_unexpected: got dout %0h, expected no output", doutA);
                end else begin
                    e = qA.pop_front();
                    compareTail("A", doutA, ovfA, e);
                end
            end
            if (!reset && ovB && orB && ceB) begin
                if (qB.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL B_unexpected: got dout %0h, expected no output", doutB);
                end else begin
                    e = qB.pop_front();
                    compareTail("B", doutB, ovfB, e);
                end
            end
            if (!reset && ovC && orC && ceC) begin
                if (qC.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL C_unexpected: got dout %0h, expected no output", doutC);
                end else begin
                    e = qC.pop_front();
                    compareTail("C", doutC, ovfC, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       savedV;
        logic [5:0] savedD;
        reset = 1'b1;
        ceA = 1'b1; ceB = 1'b1; ceC = 1'b1;
        orA = 1'b1; orB = 1'b1; orC = 1'b1;
        vldA = 1'b0; vldB = 1'b0; vldC = 1'b0;
        din0A = '0; din0B = '0; din0C = '0;
        din1A = '0; din1B = '0; din1C = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_out_vld", {31'd0, ovA}, 32'd0);
        checkOutput("rst_dout", {26'd0, doutA}, 32'd0);
        checkOutput("rst_ovf", {31'd0, ovfA}, 32'd0);
        checkOutput("rst_in_rdy", {31'd0, rdyA}, 32'd1);
        @(posedge clk); #1;

        // 5 * -3 = -15, then latency of the lone operand.
        applyStimulus(0, 6'h05, 4'hD, 6'h31, 1'b0);
        vldA = 1'b0;
        checkLatency("lat");
        @(posedge clk); #1;

        // Signed truncate: wrap and range boundaries.
        applyStimulus(0, 6'h20, 4'h8, 6'h00, 1'b1);
        applyStimulus(0, 6'h07, 4'h3, 6'h15, 1'b0);
        applyStimulus(0, 6'h3C, 4'h7, 6'h24, 1'b0);
        applyStimulus(0, 6'h1F, 4'h7, 6'h19, 1'b1);
        applyStimulus(0, 6'h20, 4'h1, 6'h20, 1'b0);
        applyStimulus(0, 6'h1F, 4'h1, 6'h1F, 1'b0);
        applyStimulus(0, 6'h20, 4'hF, 6'h20, 1'b1);
        vldA = 1'b0;

        // Signed saturate.
        applyStimulus(1, 6'h20, 4'h8, 6'h1F, 1'b1);
        applyStimulus(1, 6'h20, 4'h7, 6'h20, 1'b1);
        applyStimulus(1, 6'h05, 4'hD, 6'h31, 1'b0);
        applyStimulus(1, 6'h20, 4'hF, 6'h1F, 1'b1);
        applyStimulus(1, 6'h3F, 4'hF, 6'h01, 1'b0);
        vldB = 1'b0;

        // Unsigned saturate, with counters after the first result.
        applyStimulus(2, 6'h3F, 4'hF, 6'h3F, 1'b1);
        vldC = 1'b0;
        waitDrain("c1");
`ifdef CASE_8_MUL_PIPE_STATS_EN
        @(negedge clk);
        checkOutput("stat_acc", accC, 32'd1);
        checkOutput("stat_ovf", {16'd0, sovC}, 32'd1);
        @(posedge clk); #1;
`endif
        applyStimulus(2, 6'h07, 4'h9, 6'h3F, 1'b0);
        applyStimulus(2, 6'h08, 4'h8, 6'h3F, 1'b1);
        applyStimulus(2, 6'h03, 4'h5, 6'h0F, 1'b0);
        vldC = 1'b0;
        waitDrain("vec");

        // Back-to-back stream with the consumer stalling for four cycles.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(0, 6'(i), 4'h1, 6'(i), 1'b0);
                end
                vldA = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 orA = 1'b0;
                @(negedge clk);
                checkOutput("stall_in_rdy", {31'd0, rdyA}, 32'd0);
                savedV = ovA;
                savedD = doutA;
                @(negedge clk);
                checkOutput("stall_hold_vld", {31'd0, ovA}, {31'd0, savedV});
                checkOutput("stall_hold_dout", {26'd0, doutA}, {26'd0, savedD});
                repeat (3) @(posedge clk);
                #1 orA = 1'b1;
            end
        join
        waitDrain("stream");

        // Same kind of stream, paused by ce for three cycles.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(0, 6'(i), 4'h2, 6'(2 * i), 1'b0);
                end
                vldA = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 ceA = 1'b0;
                @(negedge clk);
                checkOutput("ce_in_rdy", {31'd0, rdyA}, 32'd0);
                savedV = ovA;
                savedD = doutA;
                repeat (2) begin
                    @(negedge clk);
                    checkOutput("ce_hold_vld", {31'd0, ovA}, {31'd0, savedV});
                    checkOutput("ce_hold_dout", {26'd0, doutA}, {26'd0, savedD});
                    checkOutput("ce_hold_rdy", {31'd0, rdyA}, 32'd0);
                end
                @(posedge clk);
                #1 ceA = 1'b1;
            end
        join
        waitDrain("ce");

        // Reset with three operands in flight discards them.
        orA = 1'b0;
        applyStimulus(0, 6'h01, 4'h1, 6'h01, 1'b0);
        applyStimulus(0, 6'h02, 4'h1, 6'h02, 1'b0);
        applyStimulus(0, 6'h03, 4'h1, 6'h03, 1'b0);
        vldA = 1'b0;
        reset = 1'b1;
        qA.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        orA = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_vld", {31'd0, ovA}, 32'd0);
        checkOutput("flush_dout", {26'd0, doutA}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(0, 6'h02, 4'h3, 6'h06, 1'b0);
        vldA = 1'b0;
        checkLatency("post_rst");
        waitDrain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
